// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: enable/flush sequencing for load-use, branch, wide MEM ops and interrupt drain.
// Define HAZARD_STATS_EN to add saturating stall_cycles/flush_events counters.
module pipeline_hazard_controller #(
  parameter int REG_NUM_W    = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_NUM_W-1:0] id_src1_num,
  input  logic [REG_NUM_W-1:0] id_src2_num,
  input  logic                 id_uses_src1,
  input  logic                 id_uses_src2,
  input  logic                 ex_mem_read,
  input  logic [REG_NUM_W-1:0] ex_dst_num,
  input  logic                 branch_taken,
  input  logic                 mem_wide_op,
  input  logic                 int_req,
  output logic                 pc_en,
  output logic                 fd_en,
  output logic                 de_en,
  output logic                 em_en,
  output logic                 mw_en,
  output logic                 fd_flush,
  output logic                 de_flush,
  output logic                 mw_flush,
  output logic                 mem_half,
  output logic                 int_ack,
`ifdef HAZARD_STATS_EN
  output logic [15:0]          stall_cycles,
  output logic [15:0]          flush_events,
`endif
  output logic [1:0]           state_dbg
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_HI = 2'd1, INT_DRAIN = 2'd2, INT_ACK = 2'd3} state_t;
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);
  state_t state, state_nxt;
  logic int_pending, hold, hold_nxt, load_use, low_half, br_hon;
  logic [CW-1:0] drain_cnt, drain_cnt_nxt;
  assign load_use = ex_mem_read && ((id_uses_src1 && id_src1_num == ex_dst_num) ||
                                    (id_uses_src2 && id_src2_num == ex_dst_num));
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      int_pending <= 1'b0;
      hold        <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      int_pending <= int_req || (int_pending && state != INT_ACK);
      hold        <= hold_nxt;
      drain_cnt   <= drain_cnt_nxt;
    end
  end
  always_comb begin
    low_half      = mem_wide_op && (state == RUN || (state == INT_DRAIN && !hold));
    br_hon        = reset && branch_taken && !low_half && state != INT_ACK;
    {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
    {fd_flush, de_flush, mw_flush} = 3'b000;
    mem_half      = state == MEM_HI || (state == INT_DRAIN && hold);
    int_ack       = state == INT_ACK;
    state_dbg     = state;
    state_nxt     = state;
    hold_nxt      = 1'b0;
    drain_cnt_nxt = drain_cnt;
    if (state == INT_DRAIN || state == INT_ACK) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
    end
    // the low half holds EX, so branch and load-use wait for the high half
    if (low_half) begin
      {pc_en, fd_en, de_en, em_en} = 4'b0000;
      mw_flush = 1'b1;
    end else if (br_hon) begin
      pc_en    = 1'b1;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (load_use && (state == RUN || state == MEM_HI)) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end
    case (state)
      RUN: begin
        if (low_half) state_nxt = MEM_HI;
        else if (!branch_taken && !load_use && int_pending) begin
          state_nxt     = INT_DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      MEM_HI: state_nxt = RUN;
      INT_DRAIN: begin
        if (low_half) hold_nxt = 1'b1;
        else if (drain_cnt == LAST) state_nxt = INT_ACK;
        else drain_cnt_nxt = drain_cnt + 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    if (!reset) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
      {fd_flush, de_flush, mw_flush} = 3'b111;
      mem_half  = 1'b0;
      int_ack   = 1'b0;
      state_dbg = 2'd0;
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (br_hon && flush_events != 16'hFFFF) flush_events <= flush_events + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed literal checks plus randomized run against a behavioural model.
module tb_pipeline_hazard_controller;
  localparam int DRAIN_CYCLES = 3;
  localparam logic [11:0] RST = 12'b00000_111_0_0_00;
  localparam logic [11:0] DEF = 12'b11111_000_0_0_00;
  localparam logic [11:0] LDU = 12'b00111_010_0_0_00;
  localparam logic [11:0] BRN = 12'b11111_110_0_0_00;
  localparam logic [11:0] WLO = 12'b00001_001_0_0_00;
  localparam logic [11:0] WHI = 12'b11111_000_1_0_01;
  localparam logic [11:0] WHB = 12'b11111_110_1_0_01;
  localparam logic [11:0] DRN = 12'b01111_100_0_0_10;
  localparam logic [11:0] ACK = 12'b01111_100_0_1_11;
  logic clk = 1'b0, reset = 1'b0;
  logic [2:0] id_src1_num = '0, id_src2_num = '0, ex_dst_num = '0;
  logic id_uses_src1 = 0, id_uses_src2 = 0, ex_mem_read = 0, branch_taken = 0, mem_wide_op = 0, int_req = 0;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush, mem_half, int_ack;
  logic [1:0] state_dbg;
  logic [11:0] dut_vec;
  int tests = 0, fails = 0, acks;
  int m_mode = 0, m_left = 0;
  bit m_pend = 0, m_hold = 0;

  pipeline_hazard_controller #(.REG_NUM_W(3), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .reset(reset), .id_src1_num(id_src1_num), .id_src2_num(id_src2_num),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .ex_mem_read(ex_mem_read),
    .ex_dst_num(ex_dst_num), .branch_taken(branch_taken), .mem_wide_op(mem_wide_op),
    .int_req(int_req), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .de_flush(de_flush), .mw_flush(mw_flush), .mem_half(mem_half),
    .int_ack(int_ack), .state_dbg(state_dbg));

  assign dut_vec = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush, mem_half, int_ack, state_dbg};
  always #5 clk = ~clk;

  function automatic bit hazard();
    return ex_mem_read && ((id_uses_src1 && id_src1_num == ex_dst_num) || (id_uses_src2 && id_src2_num == ex_dst_num));
  endfunction

  // mode: 0 run, 1 second half of wide access, 2 draining (m_left bubbles still owed), 3 acknowledging
  function automatic logic [11:0] model_out();
    logic [4:0] en;
    logic [2:0] fl;
    bit low, br;
    if (!reset) return RST;
    low = mem_wide_op && (m_mode == 0 || (m_mode == 2 && !m_hold));
    br  = branch_taken && !low && m_mode != 3;
    en  = 5'b11111;
    fl  = 3'b000;
    if (m_mode >= 2) begin en[4] = 1'b0; fl[2] = 1'b1; end
    if (low) begin en = 5'b00001; fl[0] = 1'b1; end
    else if (br) begin en[4] = 1'b1; fl[2:1] = 2'b11; end
    else if (hazard() && m_mode < 2) begin en[4:3] = 2'b00; fl[1] = 1'b1; end
    return {en, fl, m_mode == 1 || (m_mode == 2 && m_hold), m_mode == 3, 2'(m_mode)};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_mode <= 0; m_pend <= 0; m_left <= 0; m_hold <= 0;
    end else begin
      m_pend <= int_req || (m_pend && m_mode != 3);
      m_hold <= 0;
      case (m_mode)
        0: if (mem_wide_op) m_mode <= 1;
           else if (!branch_taken && !hazard() && m_pend) begin m_mode <= 2; m_left <= DRAIN_CYCLES; end
        1: m_mode <= 0;
        2: if (mem_wide_op && !m_hold) m_hold <= 1;
           else if (m_left == 1) m_mode <= 3;
           else m_left <= m_left - 1;
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [11:0] e;
    e = model_out();
    tests++;
    if (dut_vec !== e) begin
      fails++;
      $display("FAIL model t=%0t: got %b expected %b", $time, dut_vec, e);
    end
  end

  task automatic chk(input string nm, input logic [11:0] exp);
    tests++;
    if (dut_vec !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, dut_vec, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_uses_src1, id_uses_src2, ex_mem_read, branch_taken, mem_wide_op, int_req} = '0;
    id_src1_num = 0; id_src2_num = 0; ex_dst_num = 0;
  endtask

  task automatic no_ack(input string nm, input int n);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      #3 if (int_ack) acks++;
      cyc();
    end
    tests++;
    if (acks != 0) begin
      fails++;
      $display("FAIL %s: got %0d acks expected 0", nm, acks);
    end
  endtask

  initial begin
    ex_mem_read = 1; branch_taken = 1; mem_wide_op = 1; int_req = 1;
    #3 chk("reset_override", RST);
    cyc(); cyc();
    reset = 1; idle();
    #3 chk("defaults", DEF); cyc();
    ex_mem_read = 1; ex_dst_num = 3; id_src2_num = 3; id_uses_src2 = 1;
    #3 chk("load_use", LDU); cyc();
    idle();
    #3 chk("load_use_clear", DEF); cyc();
    ex_mem_read = 1; ex_dst_num = 5; id_src1_num = 5; id_uses_src1 = 1; branch_taken = 1;
    #3 chk("branch_over_load_use", BRN); cyc();
    idle();
    #3 chk("branch_one_cycle", DEF); cyc();
    mem_wide_op = 1;
    #3 chk("wide_low", WLO); cyc();
    #3 chk("wide_high", WHI); cyc();
    idle();
    #3 chk("wide_back_to_run", DEF); cyc();
    mem_wide_op = 1; branch_taken = 1;
    #3 chk("wide_branch_low", WLO); cyc();
    #3 chk("wide_branch_high", WHB); cyc();
    idle();
    int_req = 1;
    #3 chk("int_req_cycle", DEF); cyc();
    int_req = 0;
    #3 chk("int_entry", DEF); cyc();
    for (int k = 0; k < DRAIN_CYCLES; k++) begin
      int_req = (k == 0);
      #3 chk("drain", DRN); cyc();
    end
    int_req = 0;
    #3 chk("int_ack", ACK); cyc();
    #3 chk("after_ack", DEF); cyc();
    no_ack("single_ack", 6);
    int_req = 1; cyc();
    int_req = 0; cyc();
    #3 chk("drain_cnt0", DRN); cyc();
    reset = 0;
    #3 chk("reset_mid_drain", RST); cyc();
    reset = 1;
    #3 chk("post_reset_run", DEF); cyc();
    no_ack("no_ack_after_reset", 8);
    for (int i = 0; i < 4000; i++) begin
      reset        = $urandom_range(0, 59) != 0;
      int_req      = $urandom_range(0, 15) == 0;
      mem_wide_op  = $urandom_range(0, 4) == 0;
      branch_taken = $urandom_range(0, 4) == 0;
      ex_mem_read  = $urandom_range(0, 2) == 0;
      id_uses_src1 = 1'($urandom_range(0, 1));
      id_uses_src2 = 1'($urandom_range(0, 1));
      id_src1_num  = 3'($urandom_range(0, 3));
      id_src2_num  = 3'($urandom_range(0, 3));
      ex_dst_num   = 3'($urandom_range(0, 3));
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central sequencing block for the five-stage pipeline. It drives the enable and flush controls of the PC and the four pipeline registers (FD, DE, EM, MW). It resolves load-use hazards, taken-branch flushes, and two-cycle wide (32-bit) memory accesses in MEM. It also sequences an interrupt drain before acknowledging the interrupt.

Parameters:
REG_NUM_W, 3, width of register-number fields
DRAIN_CYCLES, 3, bubble cycles inserted before int_ack (pipeline depth behind ID)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
id_src1_num  in  REG_NUM_W  source reg 1 of instruction in ID
id_src2_num  in  REG_NUM_W  source reg 2 of instruction in ID
id_uses_src1  in  1  ID instruction reads src1
id_uses_src2  in  1  ID instruction reads src2
ex_mem_read  in  1  instruction in EX is a load/pop
ex_dst_num  in  REG_NUM_W  destination reg of EX instruction
branch_taken  in  1  EX resolved a taken branch/jump/call/ret
mem_wide_op  in  1  MEM instruction needs a 32-bit (two-half) access
int_req  in  1  external interrupt request pulse
pc_en, fd_en, de_en, em_en, mw_en  out  1 each  register write enables
fd_flush, de_flush, mw_flush  out  1 each  load zero control signals into that register
mem_half  out  1  0 = low half-word access, 1 = high half-word access
int_ack  out  1  one-cycle pulse: pipeline drained, interrupt may be taken
state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset: clk, reset — synchronous, active-low. While reset=0 at a posedge, the FSM goes to RUN, int_pending=0 and drain_cnt=0.
- Outputs while reset=0 (combinational override): all *_en=0, all *_flush=1, mem_half=0, int_ack=0, state_dbg=0.
- States and encodings: RUN=0, MEM_HI=1, INT_DRAIN=2, INT_ACK=3. Outputs are combinational from the state and the current inputs.
- Defaults (no event): all enables=1, all flushes=0, mem_half=0.
- Load-use condition: ex_mem_read and ((id_uses_src1 and id_src1_num==ex_dst_num) or (id_uses_src2 and id_src2_num==ex_dst_num)).
- Priority per cycle: wide-op stall > branch > load-use > interrupt entry.

RUN state:
  - mem_wide_op=1: low half. mem_half=0; pc_en=fd_en=de_en=em_en=0; mw_flush=1. Branch and load-use are ignored this cycle (EX is held). Next state is MEM_HI.
  - branch_taken=1: pc_en=1; fd_flush=1; de_flush=1. Load-use is suppressed because the ID instruction is squashed.
  - load-use: pc_en=0; fd_en=0; de_flush=1. This produces one bubble and the condition clears the following cycle.
  - int_pending and none of the above: next state is INT_DRAIN, drain_cnt=0.

MEM_HI state:
  - mem_half=1; enables default; mem_wide_op is ignored.
  - Branch and load-use are evaluated as in RUN.
  - Next state is RUN. A back-to-back wide op is caught in RUN the next cycle.

INT_DRAIN state:
  - pc_en=0; fd_flush=1 (bubbles enter ID). Older instructions keep advancing.
  - A wide op in MEM uses the same two-cycle sequence via a hold bit, and drain_cnt does not advance during the low half.
  - branch_taken: pc_en=1 so the target is captured, plus fd_flush=1 and de_flush=1.
  - drain_cnt increments each non-held cycle. When it reaches DRAIN_CYCLES-1, next state is INT_ACK.

INT_ACK state:
  - int_ack=1 for one cycle; pc_en=0; fd_flush=1.
  - int_pending clears. Next state is RUN.

int_pending:
  - Set by int_req=1 at any posedge outside reset.
  - A request arriving in INT_ACK re-sets int_pending after the clear, because set wins.
  - Multiple requests before the ack merge into one.

Reset mid-operation: any state returns to RUN, the pending interrupt and hold bit are discarded, and there is no ack.

Optional Feature:
HAZARD_STATS_EN: adds outputs stall_cycles[15:0] and flush_events[15:0], both saturating at 16'hFFFF and cleared by reset.
- stall_cycles increments each cycle with pc_en=0 outside reset.
- flush_events increments each cycle with branch_taken honoured.
- Without the macro, these ports and counters do not exist.

Test Plan:
- Load-use: ex_mem_read=1, ex_dst_num=3, id_src2_num=3, id_uses_src2=1 -> one cycle with pc_en=0, fd_en=0, de_flush=1, then defaults.
- Branch: branch_taken=1 in RUN -> fd_flush=1, de_flush=1, pc_en=1 for exactly one cycle. Simultaneous load-use produces no stall.
- Wide op: mem_wide_op=1 for two cycles -> cycle 1 mem_half=0, em_en=0, mw_flush=1; cycle 2 mem_half=1, em_en=1; state_dbg 0→1→0.
- Wide op plus branch: branch_taken held during the low half -> flush occurs only in the MEM_HI cycle.
- Interrupt: int_req pulse in idle RUN -> 3 cycles INT_DRAIN with pc_en=0, fd_flush=1, then int_ack=1 once, then RUN. A second int_req during drain yields a single ack.
- Reset mid-drain: reset=0 at drain_cnt=1 -> all enables 0, all flushes 1; after release the state is RUN and int_ack never asserts.
